// File: rtl/ttl_74593_sequencer.sv
// ----------------------------------------------------------------------------
// ttl_74593_sequencer
//
// Command-driven controller for one 74593 counter/register package sharing a
// tri-state bus. Single-cycle commands (clear, load, increment-by-N, read) are
// expanded into ordered pin sequences. A shadow copy of the counter is kept
// and every read-back is compared against it.
//
// Ports:
//   Clk, Reset          clock; asynchronous active-high reset
//   Cmd[1:0]            00 clear, 01 load, 10 increment, 11 read
//   Cmd_valid/ready     command handshake (accepted when both high at Clk edge)
//   Load_data           load value, sampled at accept
//   Incr_count          number of increments, sampled at accept
//   Done                one-cycle completion pulse
//   Rd_data             value captured by the last read
//   Mismatch            with Done of a read: Rd_data differs from valid shadow
//   Bus_in              counter Q as seen on the shared bus
//   CCK..G_bar, inQ     registered drives for the 74593 pins
// ----------------------------------------------------------------------------
module ttl_74593_sequencer #(
   parameter int WIDTH        = 8,
   parameter int PULSE_CYCLES = 1,
   parameter int DRIVE_CYCLES = 2
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [1:0]       Cmd,
   input  logic             Cmd_valid,
   output logic             Cmd_ready,
   input  logic [WIDTH-1:0] Load_data,
   input  logic [WIDTH-1:0] Incr_count,
   output logic             Done,
   output logic [WIDTH-1:0] Rd_data,
   output logic             Mismatch,
   input  logic [WIDTH-1:0] Bus_in,
   output logic             CCK,
   output logic             CCKEN,
   output logic             CCKEN_bar,
   output logic             CLOAD_bar,
   output logic             CCLR_bar,
   output logic             RCK,
   output logic             RCKEN_bar,
   output logic             G,
   output logic             G_bar,
   output logic [WIDTH-1:0] inQ
);

   localparam logic [1:0] CMD_CLEAR = 2'b00;
   localparam logic [1:0] CMD_LOAD  = 2'b01;
   localparam logic [1:0] CMD_INCR  = 2'b10;
   localparam logic [1:0] CMD_READ  = 2'b11;

   // The timer holds "cycles remaining minus one" for the timed states.
   localparam int TMAX = (PULSE_CYCLES > DRIVE_CYCLES) ? PULSE_CYCLES : DRIVE_CYCLES;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   typedef enum logic [3:0] {
      IDLE, CLR, LD_SETUP, LD_RCK, LD_CNT, INC_HI, INC_LO, DRIVE, TURN, DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] incr_q, incr_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             shadow_valid_q, shadow_valid_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             mismatch_q, mismatch_d;

   logic             cck_q, cck_d;
   logic             ccken_q, ccken_d;
   logic             ccken_bar_q, ccken_bar_d;
   logic             cload_bar_q, cload_bar_d;
   logic             cclr_bar_q, cclr_bar_d;
   logic             rck_q, rck_d;
   logic             rcken_bar_q, rcken_bar_d;
   logic             g_q, g_d;
   logic             g_bar_q, g_bar_d;
   logic [WIDTH-1:0] inq_q, inq_d;
   logic             done_q, done_d;
   logic             cmd_ready_q, cmd_ready_d;

   // ------------------------------------------------------------------------
   // Next-state and datapath
   // ------------------------------------------------------------------------
   always_comb begin
      state_d        = state_q;
      data_d         = data_q;
      incr_d         = incr_q;
      rem_d          = rem_q;
      timer_d        = timer_q;
      shadow_d       = shadow_q;
      shadow_valid_d = shadow_valid_q;
      rd_data_d      = rd_data_q;
      mismatch_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (Cmd_valid && cmd_ready_q) begin
               data_d = Load_data;
               incr_d = Incr_count;
               case (Cmd)
                  CMD_CLEAR: begin
                     state_d = CLR;
                     timer_d = TW'(PULSE_CYCLES - 1);
                  end
                  CMD_LOAD: state_d = LD_SETUP;
                  CMD_INCR: begin
                     if (Incr_count == '0) begin
                        state_d = DONE;
                     end else begin
                        state_d = INC_HI;
                        rem_d   = Incr_count;
                     end
                  end
                  CMD_READ: begin
                     state_d = DRIVE;
                     timer_d = TW'(DRIVE_CYCLES - 1);
                  end
                  default: state_d = IDLE;
               endcase
            end
         end
         CLR: begin
            if (timer_q == '0) begin
               state_d        = DONE;
               shadow_d       = '0;
               shadow_valid_d = 1'b1;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         LD_SETUP: state_d = LD_RCK;
         LD_RCK: begin
            state_d = LD_CNT;
            timer_d = TW'(PULSE_CYCLES - 1);
         end
         LD_CNT: begin
            if (timer_q == '0) begin
               state_d        = DONE;
               shadow_d       = data_q;
               shadow_valid_d = 1'b1;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         INC_HI: state_d = INC_LO;
         INC_LO: begin
            rem_d = rem_q - WIDTH'(1);
            if (rem_q == WIDTH'(1)) begin
               state_d  = DONE;
               shadow_d = shadow_q + incr_q;   // wraps modulo 2^WIDTH
            end else begin
               state_d = INC_HI;
            end
         end
         DRIVE: begin
            if (timer_q == '0) begin
               // Capture on the edge that ends the last driven cycle.
               rd_data_d = Bus_in;
               state_d   = TURN;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         TURN: begin
            state_d    = DONE;
            mismatch_d = shadow_valid_q && (rd_data_q != shadow_q);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Pin outputs are decoded from the next state and registered, so each pin
   // is a clean flop output that exactly tracks the current state.
   // ------------------------------------------------------------------------
   always_comb begin
      cck_d       = 1'b0;
      ccken_d     = 1'b0;
      cload_bar_d = 1'b1;
      cclr_bar_d  = 1'b1;
      rck_d       = 1'b0;
      rcken_bar_d = 1'b1;
      g_d         = 1'b0;
      inq_d       = '0;
      done_d      = 1'b0;
      cmd_ready_d = 1'b0;

      case (state_d)
         IDLE:     cmd_ready_d = 1'b1;
         CLR:      cclr_bar_d  = 1'b0;
         LD_SETUP: begin
            inq_d       = data_d;
            rcken_bar_d = 1'b0;
         end
         LD_RCK: begin
            inq_d       = data_d;
            rcken_bar_d = 1'b0;
            rck_d       = 1'b1;
         end
         LD_CNT: begin
            inq_d       = data_d;
            cload_bar_d = 1'b0;
         end
         INC_HI: begin
            ccken_d = 1'b1;
            cck_d   = 1'b1;
         end
         INC_LO:   ccken_d = 1'b1;
         DRIVE:    g_d     = 1'b1;
         DONE:     done_d  = 1'b1;
         default:  cmd_ready_d = 1'b0;
      endcase

      ccken_bar_d = ~ccken_d;
      g_bar_d     = ~g_d;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q        <= IDLE;
         data_q         <= '0;
         incr_q         <= '0;
         rem_q          <= '0;
         timer_q        <= '0;
         shadow_q       <= '0;
         shadow_valid_q <= 1'b0;
         rd_data_q      <= '0;
         mismatch_q     <= 1'b0;
         cck_q          <= 1'b0;
         ccken_q        <= 1'b0;
         ccken_bar_q    <= 1'b1;
         cload_bar_q    <= 1'b1;
         cclr_bar_q     <= 1'b1;
         rck_q          <= 1'b0;
         rcken_bar_q    <= 1'b1;
         g_q            <= 1'b0;
         g_bar_q        <= 1'b1;
         inq_q          <= '0;
         done_q         <= 1'b0;
         cmd_ready_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         data_q         <= data_d;
         incr_q         <= incr_d;
         rem_q          <= rem_d;
         timer_q        <= timer_d;
         shadow_q       <= shadow_d;
         shadow_valid_q <= shadow_valid_d;
         rd_data_q      <= rd_data_d;
         mismatch_q     <= mismatch_d;
         cck_q          <= cck_d;
         ccken_q        <= ccken_d;
         ccken_bar_q    <= ccken_bar_d;
         cload_bar_q    <= cload_bar_d;
         cclr_bar_q     <= cclr_bar_d;
         rck_q          <= rck_d;
         rcken_bar_q    <= rcken_bar_d;
         g_q            <= g_d;
         g_bar_q        <= g_bar_d;
         inq_q          <= inq_d;
         done_q         <= done_d;
         cmd_ready_q    <= cmd_ready_d;
      end
   end

   assign Cmd_ready = cmd_ready_q;
   assign Done      = done_q;
   assign Rd_data   = rd_data_q;
   assign Mismatch  = mismatch_q;
   assign CCK       = cck_q;
   assign CCKEN     = ccken_q;
   assign CCKEN_bar = ccken_bar_q;
   assign CLOAD_bar = cload_bar_q;
   assign CCLR_bar  = cclr_bar_q;
   assign RCK       = rck_q;
   assign RCKEN_bar = rcken_bar_q;
   assign G         = g_q;
   assign G_bar     = g_bar_q;
   assign inQ       = inq_q;

endmodule

// File: tb/tb_ttl_74593_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ttl_74593_sequencer
//
// Directed bench for ttl_74593_sequencer (WIDTH=8, PULSE_CYCLES=1,
// DRIVE_CYCLES=2). Each command is issued, its pin trace is recorded on the
// falling edge, and the trace, completion cycle and read results are compared
// with hand-computed values.
// ----------------------------------------------------------------------------
module tb_ttl_74593_sequencer;

   // Pin vector order: {CCK, CCKEN, CCKEN_bar, CLOAD_bar, CCLR_bar, RCK, RCKEN_bar, G, G_bar}
   localparam logic [8:0] P_IDLE = 9'b001110101;
   localparam logic [8:0] P_CLR  = 9'b001100101;
   localparam logic [8:0] P_LDS  = 9'b001110001;
   localparam logic [8:0] P_LDR  = 9'b001111001;
   localparam logic [8:0] P_LDC  = 9'b001010101;
   localparam logic [8:0] P_INH  = 9'b110110101;
   localparam logic [8:0] P_INL  = 9'b010110101;
   localparam logic [8:0] P_DRV  = 9'b001110110;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [1:0] Cmd = 2'b00;
   logic       Cmd_valid = 1'b0;
   logic       Cmd_ready;
   logic [7:0] Load_data = 8'h00;
   logic [7:0] Incr_count = 8'h00;
   logic       Done;
   logic [7:0] Rd_data;
   logic       Mismatch;
   logic [7:0] Bus_in = 8'h00;
   logic       CCK, CCKEN, CCKEN_bar, CLOAD_bar, CCLR_bar, RCK, RCKEN_bar, G, G_bar;
   logic [7:0] inQ;

   ttl_74593_sequencer #(.WIDTH(8), .PULSE_CYCLES(1), .DRIVE_CYCLES(2)) dut (
      .Clk(Clk), .Reset(Reset), .Cmd(Cmd), .Cmd_valid(Cmd_valid), .Cmd_ready(Cmd_ready),
      .Load_data(Load_data), .Incr_count(Incr_count), .Done(Done), .Rd_data(Rd_data),
      .Mismatch(Mismatch), .Bus_in(Bus_in), .CCK(CCK), .CCKEN(CCKEN), .CCKEN_bar(CCKEN_bar),
      .CLOAD_bar(CLOAD_bar), .CCLR_bar(CCLR_bar), .RCK(RCK), .RCKEN_bar(RCKEN_bar),
      .G(G), .G_bar(G_bar), .inQ(inQ)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [8:0] tr_pins [0:63];
   logic [7:0] tr_inq  [0:63];
   logic [8:0] exp_q [$];
   int         done_at;
   logic [7:0] rd_at_done;
   logic       mm_at_done;
   int         other_mm;
   int         excl_viol;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] pins();
      return {CCK, CCKEN, CCKEN_bar, CLOAD_bar, CCLR_bar, RCK, RCKEN_bar, G, G_bar};
   endfunction

   // Issue one command and record the trace up to and including Done.
   task automatic run_cmd(input string name, input logic [1:0] cmd, input logic [7:0] data,
                          input logic [7:0] incr, input bit hold);
      int sel;
      @(negedge Clk);
      check_eq({name, "_ready"}, 32'(Cmd_ready), 32'd1);
      Cmd = cmd; Load_data = data; Incr_count = incr; Cmd_valid = 1'b1;
      done_at = -1; other_mm = 0; excl_viol = 0;
      @(posedge Clk);
      for (int k = 1; k < 64; k++) begin
         @(negedge Clk);
         if (!hold) Cmd_valid = 1'b0;
         tr_pins[k] = pins();
         tr_inq[k]  = inQ;
         sel = int'(!CCLR_bar) + int'(!CLOAD_bar) + int'(RCK) + int'(CCK) + int'(G);
         if (sel > 1) excl_viol++;
         if (Done) begin
            done_at    = k;
            rd_at_done = Rd_data;
            mm_at_done = Mismatch;
            break;
         end else if (Mismatch) begin
            other_mm++;
         end
      end
      $display("cmd %s: done_at=%0d rd=0x%02h mm=%0b", name, done_at, rd_at_done, mm_at_done);
      check_eq({name, "_exclusive"}, 32'(excl_viol), 32'd0);
   endtask

   task automatic check_trace(input string tag);
      for (int i = 0; i < exp_q.size(); i++)
         check_eq($sformatf("%s_pins_c%0d", tag, i + 1), 32'(tr_pins[i + 1]), 32'(exp_q[i]));
   endtask

   task automatic do_read(input string name, input logic [7:0] bus, input logic exp_mm);
      Bus_in = bus;
      run_cmd(name, 2'b11, 8'h00, 8'h00, 1'b0);
      check_eq({name, "_done_cycle"}, 32'(done_at), 32'd4);
      check_eq({name, "_rd_data"}, 32'(rd_at_done), 32'(bus));
      check_eq({name, "_mismatch"}, 32'(mm_at_done), 32'(exp_mm));
      check_eq({name, "_mm_outside_done"}, 32'(other_mm), 32'd0);
   endtask

   task automatic do_incr(input string name, input logic [7:0] n);
      run_cmd(name, 2'b10, 8'h00, n, 1'b0);
      check_eq({name, "_done_cycle"}, 32'(done_at), 32'(2 * int'(n) + 1));
      exp_q = {};
      for (int i = 0; i < int'(n); i++) begin
         exp_q.push_back(P_INH);
         exp_q.push_back(P_INL);
      end
      exp_q.push_back(P_IDLE);
      check_trace(name);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      @(negedge Clk);
      check_eq("rst_pins", 32'(pins()), 32'(P_IDLE));
      check_eq("rst_inq", 32'(inQ), 32'h0);
      check_eq("rst_ready", 32'(Cmd_ready), 32'd0);
      check_eq("rst_done", 32'(Done), 32'd0);
      check_eq("rst_rd_data", 32'(Rd_data), 32'h0);
      check_eq("rst_mismatch", 32'(Mismatch), 32'd0);
      Reset = 1'b0;
      @(negedge Clk);
      check_eq("post_rst_ready", 32'(Cmd_ready), 32'd1);

      // Read with invalid shadow
      do_read("read5a", 8'h5A, 1'b0);
      exp_q = '{P_DRV, P_DRV, P_IDLE, P_IDLE};
      check_trace("read5a");

      // Load 0xA5
      run_cmd("loada5", 2'b01, 8'hA5, 8'h00, 1'b0);
      check_eq("loada5_done_cycle", 32'(done_at), 32'd4);
      exp_q = '{P_LDS, P_LDR, P_LDC, P_IDLE};
      check_trace("loada5");
      for (int i = 1; i <= 3; i++)
         check_eq($sformatf("loada5_inq_c%0d", i), 32'(tr_inq[i]), 32'hA5);
      check_eq("loada5_inq_done", 32'(tr_inq[4]), 32'h00);
      do_read("reada5", 8'hA5, 1'b0);
      do_read("reada4", 8'hA4, 1'b1);

      // Clear then increment by 3
      run_cmd("clear", 2'b00, 8'h00, 8'h00, 1'b0);
      check_eq("clear_done_cycle", 32'(done_at), 32'd2);
      exp_q = '{P_CLR, P_IDLE};
      check_trace("clear");
      do_incr("incr3", 8'd3);
      do_read("read03", 8'h03, 1'b0);
      do_read("read04", 8'h04, 1'b1);

      // Wrap: 0xFE + 3 = 0x01
      run_cmd("loadfe", 2'b01, 8'hFE, 8'h00, 1'b0);
      check_eq("loadfe_done_cycle", 32'(done_at), 32'd4);
      do_incr("incr3w", 8'd3);
      do_read("read01", 8'h01, 1'b0);
      do_read("read00", 8'h00, 1'b1);

      // Increment by zero
      do_incr("incr0", 8'd0);
      do_read("read01b", 8'h01, 1'b0);

      // Reset during INC_HI of a 5-increment command
      @(negedge Clk);
      Cmd = 2'b10; Incr_count = 8'd5; Cmd_valid = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Cmd_valid = 1'b0;
      check_eq("inc5_hi_cck", 32'(CCK), 32'd1);
      Reset = 1'b1;
      #1;
      check_eq("inc5_rst_cck", 32'(CCK), 32'd0);
      check_eq("inc5_rst_ccken", 32'(CCKEN), 32'd0);
      check_eq("inc5_rst_ccken_bar", 32'(CCKEN_bar), 32'd1);
      @(negedge Clk);
      check_eq("inc5_rst_ready", 32'(Cmd_ready), 32'd0);
      Reset = 1'b0;
      @(negedge Clk);
      check_eq("inc5_release_ready", 32'(Cmd_ready), 32'd1);
      $display("cmd reset_mid_incr: released");
      do_read("read77", 8'h77, 1'b0);

      // Cmd_valid held high while busy
      run_cmd("clear2", 2'b00, 8'h00, 8'h00, 1'b0);
      Bus_in = 8'h00;
      run_cmd("hold_incr2", 2'b10, 8'h00, 8'd2, 1'b1);
      check_eq("hold_done_cycle", 32'(done_at), 32'd5);
      exp_q = '{P_INH, P_INL, P_INH, P_INL, P_IDLE};
      check_trace("hold");
      @(negedge Clk);
      check_eq("hold_idle_ready", 32'(Cmd_ready), 32'd1);
      check_eq("hold_idle_pins", 32'(pins()), 32'(P_IDLE));
      check_eq("hold_idle_done", 32'(Done), 32'd0);
      @(negedge Clk);
      Cmd_valid = 1'b0;
      check_eq("hold_reaccept_cck", 32'(CCK), 32'd1);
      check_eq("hold_reaccept_ready", 32'(Cmd_ready), 32'd0);
      done_at = -1;
      for (int k = 1; k < 20; k++) begin
         @(negedge Clk);
         if (Done) begin
            done_at = k;
            break;
         end
      end
      check_eq("hold_second_done", 32'(done_at), 32'd4);
      $display("cmd hold_incr2_second: done_at=%0d", done_at);
      do_read("read_hold04", 8'h04, 1'b0);
      do_read("read_hold02", 8'h02, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
